// File: rtl/regfile_wb_pkg.sv
// Purpose : shared widths, the zero-register index and the write-buffer record for regfile_wb.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
//
// Contents: ADDR_W/DATA_W/NREGS constants, REG_ZERO, wb_buf_t {valid, dest, data},
//           and wb_capture(), which builds the next buffer record from a write request.
package regfile_wb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    // Index 0 is hard-wired to zero; writes to it are dropped.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_buf_t;

    // An idle or dropped request clears the whole record, not just valid,
    // so wb_dest reads back 0 whenever nothing is pending.
    function automatic wb_buf_t wb_capture(input logic              wreg,
                                           input logic [ADDR_W-1:0] dest,
                                           input logic [DATA_W-1:0] wdata);
        wb_buf_t r;
        r = '0;
        if (wreg && (dest != REG_ZERO)) begin
            r.valid = 1'b1;
            r.dest  = dest;
            r.data  = wdata;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// Purpose : groups the write request, the two read ports and the buffer status of regfile_wb.
// Latency : n/a (wiring only).
// Backpr. : none; the register file always accepts a write and always answers a read.
//
// Signals : wreg/dest/wdata (write request), rs/rt (read indices), qa/qb (read data),
//           wb_pend/wb_dest (write-buffer status).
// master  : drives requests and indices, observes read data and status.
// slave   : the register file itself.
interface regfile_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wreg;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic              wb_pend;
    logic [ADDR_W-1:0] wb_dest;

    modport master (
        output wreg, dest, wdata, rs, rt,
        input  qa, qb, wb_pend, wb_dest
    );

    modport slave (
        input  wreg, dest, wdata, rs, rt,
        output qa, qb, wb_pend, wb_dest
    );
endinterface

// File: rtl/regfile_fwd_mux.sv
// Purpose : per-port read select: zero register, forward from the write buffer, or array contents.
// Latency : combinational.
// Backpr. : none.
//
// Ports   : idx_i (read index), buf_i (current write-buffer record),
//           arr_dat_i (array[idx_i]), q_o (read data).
module regfile_fwd_mux
    import regfile_wb_pkg::*;
(
    input  logic [ADDR_W-1:0] idx_i,
    input  wb_buf_t           buf_i,
    input  logic [DATA_W-1:0] arr_dat_i,
    output logic [DATA_W-1:0] q_o
);

    always_comb begin
        q_o = arr_dat_i;
        if (idx_i == REG_ZERO) begin
            q_o = '0;
        end else if (buf_i.valid && (buf_i.dest == idx_i)) begin
            // The buffered write is newer than the array, so it must win.
            q_o = buf_i.data;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Purpose : 32-entry register file with a one-deep write-back buffer and read forwarding.
// Latency : write in cycle N is readable (forwarded) in N+1 and resident in the array from N+2.
// Backpr. : none; one write accepted every cycle, the buffer drains one entry per edge.
//
// Ports   : clk (rising edge), rst (async, active-high),
//           bus (slave modport: wreg/dest/wdata in, rs/rt in, qa/qb out, wb_pend/wb_dest out).
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic         clk,
    input  logic         rst,
    regfile_wb_if.slave  bus
);

    import regfile_wb_pkg::wb_buf_t;
    import regfile_wb_pkg::wb_capture;

    // The buffer record is a package type, so the module widths have to agree with it.
    if ((NREGS != (1 << ADDR_W)) ||
        (DATA_W != regfile_wb_pkg::DATA_W) ||
        (ADDR_W != regfile_wb_pkg::ADDR_W)) begin : g_param_chk
        $error("regfile_wb: NREGS must be 2**ADDR_W and widths must match regfile_wb_pkg");
    end

    logic [DATA_W-1:0] regs_q [NREGS];
    wb_buf_t           buf_q;
    wb_buf_t           buf_d;
    logic [DATA_W-1:0] arr_a;
    logic [DATA_W-1:0] arr_b;

    assign buf_d = wb_capture(bus.wreg, bus.dest, bus.wdata);

    // Write buffer: reloaded every edge, so a dropped or idle request clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    // Array: commits the buffered write in the same edge that the buffer takes the next one.
    // Entry 0 is never committed because a zero dest never becomes valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (buf_q.valid) begin
            regs_q[buf_q.dest] <= buf_q.data;
        end
    end

    assign arr_a = regs_q[bus.rs];
    assign arr_b = regs_q[bus.rt];

    regfile_fwd_mux u_mux_a (
        .idx_i     (bus.rs),
        .buf_i     (buf_q),
        .arr_dat_i (arr_a),
        .q_o       (bus.qa)
    );

    regfile_fwd_mux u_mux_b (
        .idx_i     (bus.rt),
        .buf_i     (buf_q),
        .arr_dat_i (arr_b),
        .q_o       (bus.qb)
    );

    assign bus.wb_pend = buf_q.valid;
    assign bus.wb_dest = buf_q.dest;

endmodule

// File: tb/tb_regfile_wb.sv
// Purpose : self-checking bench for regfile_wb: directed table, reset corner cases, random traffic.
// Latency : n/a.
// Backpr. : n/a.
module tb_regfile_wb;

    logic clk;
    logic rst;
    logic clk_run;

    regfile_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    int errors;
    int checks;

    // Reader-visible value of every register: a write becomes visible the cycle after it is
    // presented, whether or not it has reached the array yet.
    logic [31:0] vis [32];
    logic        m_pend;
    logic [4:0]  m_dest;

    typedef struct {
        logic        wreg;
        logic [4:0]  dest;
        logic [31:0] wdata;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] eqa;
        logic [31:0] eqb;
        logic        epend;
        logic [4:0]  edest;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] d, input logic [31:0] wd,
                         input logic [4:0] a, input logic [4:0] b);
        bus.wreg  = w;
        bus.dest  = d;
        bus.wdata = wd;
        bus.rs    = a;
        bus.rt    = b;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) vis[i] = '0;
        m_pend = 1'b0;
        m_dest = '0;
    endtask

    // Apply the effect of the coming edge to the reference model.
    task automatic model_edge(input logic w, input logic [4:0] d, input logic [31:0] wd);
        m_pend = w && (d != 5'd0);
        m_dest = m_pend ? d : 5'd0;
        if (m_pend) vis[d] = wd;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : vis[idx];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors  = 0;
        checks  = 0;
        clk_run = 1'b0;
        rst     = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        model_reset();

        tbl[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 5'd3};
        tbl[2]  = '{1'b1, 5'd0, 32'h12345678, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 5'd0};
        tbl[3]  = '{1'b1, 5'd7, 32'h1,        5'd0, 5'd7, 32'h0,        32'h0,        1'b0, 5'd0};
        tbl[4]  = '{1'b1, 5'd7, 32'h2,        5'd0, 5'd7, 32'h0,        32'h1,        1'b1, 5'd7};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 32'h2,        32'h2,        1'b1, 5'd7};
        tbl[6]  = '{1'b1, 5'd4, 32'hA,        5'd4, 5'd9, 32'h0,        32'h0,        1'b0, 5'd0};
        tbl[7]  = '{1'b1, 5'd9, 32'hB,        5'd4, 5'd9, 32'hA,        32'h0,        1'b1, 5'd4};
        tbl[8]  = '{1'b1, 5'd4, 32'hC,        5'd4, 5'd9, 32'hA,        32'hB,        1'b1, 5'd9};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        5'd4, 5'd9, 32'hC,        32'hB,        1'b1, 5'd4};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd4, 32'h2,        32'hC,        1'b0, 5'd0};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 5'd0};

        // Reset with the clock stopped: outputs must clear without any edge.
        #3 rst = 1'b1;
        #1;
        chk("rst_qa",      bus.qa,               32'h0);
        chk("rst_qb",      bus.qb,               32'h0);
        chk("rst_wb_pend", {31'h0, bus.wb_pend}, 32'h0);
        chk("rst_wb_dest", {27'h0, bus.wb_dest}, 32'h0);
        #6 rst = 1'b0;
        clk_run = 1'b1;
        next_cycle();
        next_cycle();

        // Directed table: each row's outputs are those seen during the cycle its inputs are applied.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].wreg, tbl[i].dest, tbl[i].wdata, tbl[i].rs, tbl[i].rt);
            #1;
            chk($sformatf("tbl%0d_qa", i),   bus.qa,               tbl[i].eqa);
            chk($sformatf("tbl%0d_qb", i),   bus.qb,               tbl[i].eqb);
            chk($sformatf("tbl%0d_pend", i), {31'h0, bus.wb_pend}, {31'h0, tbl[i].epend});
            if (tbl[i].epend)
                chk($sformatf("tbl%0d_wbdest", i), {27'h0, bus.wb_dest}, {27'h0, tbl[i].edest});
            next_cycle();
            model_edge(tbl[i].wreg, tbl[i].dest, tbl[i].wdata);
        end

        // Reset while a write sits in the buffer: the write is lost and the array clears.
        drive(1'b1, 5'd12, 32'h55, 5'd12, 5'd3);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd3);
        #1;
        chk("mid_fwd_qa",   bus.qa,               32'h55);
        chk("mid_pend",     {31'h0, bus.wb_pend}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_qa",   bus.qa,               32'h0);
        chk("mid_rst_qb",   bus.qb,               32'h0);
        chk("mid_rst_pend", {31'h0, bus.wb_pend}, 32'h0);
        #1 rst = 1'b0;
        model_reset();
        next_cycle();
        next_cycle();
        chk("post_rst_r12", bus.qa,               32'h0);
        chk("post_rst_r3",  bus.qb,               32'h0);
        chk("post_rst_pend", {31'h0, bus.wb_pend}, 32'h0);

        // First edge after release is a fresh capture.
        drive(1'b1, 5'd12, 32'h66, 5'd12, 5'd12);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd12);
        #1;
        chk("fresh_qa",   bus.qa,               32'h66);
        chk("fresh_pend", {31'h0, bus.wb_pend}, 32'h1);
        next_cycle();
        model_edge(1'b1, 5'd12, 32'h66);
        model_edge(1'b0, 5'd0, 32'h0);

        // Random traffic against the reference model, biased to a few indices for hazards.
        for (int n = 0; n < 400; n++) begin
            logic        w;
            logic [4:0]  d, a, b;
            logic [31:0] wd;
            w  = ($urandom_range(0, 3) != 0);
            d  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
            a  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
            b  = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            wd = $urandom;
            drive(w, d, wd, a, b);
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b1;
                #1 rst = 1'b0;
                model_reset();
            end
            #1;
            chk("rnd_qa",   bus.qa,               model_read(a));
            chk("rnd_qb",   bus.qb,               model_read(b));
            chk("rnd_pend", {31'h0, bus.wb_pend}, {31'h0, m_pend});
            if (m_pend) chk("rnd_wbdest", {27'h0, bus.wb_dest}, {27'h0, m_dest});
            next_cycle();
            model_edge(w, d, wd);
        end

        // Drain the buffer, then sweep every index through both ports.
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        next_cycle();
        model_edge(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            bus.rs = 5'(i);
            bus.rt = 5'(31 - i);
            #1;
            chk($sformatf("sweep_a%0d", i), bus.qa, model_read(5'(i)));
            chk($sformatf("sweep_b%0d", i), bus.qb, model_read(5'(31 - i)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- 32-entry general-purpose register file with a one-deep write-back buffer.
- Sits directly downstream of the destination-select stage. It consumes the selected 5-bit destination index, the write-enable and the result data.
- Serves two combinational read ports (rs, rt) to the decode/ALU path.
- The write buffer decouples the write timing from the array update. Forwarding logic hides the extra cycle from readers.

Parameters:
- DATA_W, 32, width of each register and data ports
- ADDR_W, 5, register index width
- NREGS, 32, number of registers (must equal 2**ADDR_W)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- wreg  input  1  write request for this cycle
- dest  input  ADDR_W  destination index from destination-select stage
- wdata  input  DATA_W  write data
- rs  input  ADDR_W  read index, port A
- rt  input  ADDR_W  read index, port B
- qa  output  DATA_W  read data, port A
- qb  output  DATA_W  read data, port B
- wb_pend  output  1  write buffer holds an uncommitted write
- wb_dest  output  ADDR_W  index held in write buffer (debug/hazard visibility)

Behaviour:
- Interface: one clock (clk). rst is asynchronous and active-high. All state clears immediately on rst assertion, independent of clk.
- Reset values:
  - all NREGS array entries = 0
  - buffer valid = 0, buffer dest = 0, buffer data = 0
  - wb_pend = 0, wb_dest = 0
  - qa/qb = 0, since reads return array contents
- Capture: at a rising edge with wreg=1 and dest!=0, the buffer loads {valid=1, dest, wdata}.
  - If wreg=0 or dest=0, the buffer loads valid=0.
  - Writes to index 0 are discarded and never become pending.
- Commit: at every rising edge where buffer valid=1, array[buffer dest] <= buffer data. This happens in the same edge as the new capture.
- Latency: a write presented in cycle N is in the buffer during cycle N+1 and in the array from cycle N+2 onward.
- Read path is combinational:
  - index 0 -> 0
  - else if buffer valid and buffer dest == index -> buffer data (forward)
  - else -> array[index]
- Same-cycle read of the index currently on dest/wdata (not yet captured) returns the old value. Visibility starts the following cycle.
- Back-to-back writes to the same index: each edge commits the older write and captures the newer one. Readers always see the newest captured value; the array ends with the last.
- Back-to-back writes to different indices: no stalls, one commit per edge.
- rs == rt: both ports return identical data.
- wb_pend = buffer valid; wb_dest = buffer dest.
- Reset asserted mid-operation: a pending buffered write is lost. The array clears to 0. After rst deasserts, the first edge behaves as a fresh capture.
- No X propagation: reading any index after reset yields a defined value.

Decomposition:
- Shared package:
  - register-index and data-width constants (ADDR_W, DATA_W)
  - REG_ZERO index constant
  - write-buffer record typedef {valid, dest, data}
- One sub-module: regfile_fwd_mux. Purely combinational per-port select (zero / forward / array), instantiated twice for qa and qb.
- Array, buffer register and commit logic live in the top module.

Test Plan:
- Reset check: assert rst mid-cycle with clk stopped; read rs=5, rt=31 -> qa=0, qb=0, wb_pend=0 immediately.
- Basic write/read:
  - stimulus: wreg=1, dest=3, wdata=0xDEADBEEF at edge 1, then wreg=0
  - cycle after edge 1: rs=3 -> qa=0xDEADBEEF via forward, wb_pend=1, wb_dest=3
  - after edge 2: qa=0xDEADBEEF from array, wb_pend=0
- Zero register: wreg=1, dest=0, wdata=0x12345678 -> wb_pend stays 0; rs=0 -> qa=0 in all following cycles.
- Consecutive same-index writes:
  - stimulus: dest=7 with 0x1 then 0x2 on successive edges
  - rt=7 returns 0x1, then 0x2, then 0x2 after commit
  - array[7]=0x2 after the final commit
- Interleaved writes with reads:
  - writes: dest=4/0xA, dest=9/0xB, dest=4/0xC on three edges
  - reads: rs=4, rt=9 each cycle -> (qa,qb) = (0xA,old9), (0xA,0xB), (0xC,0xB)
- Reset mid-write: capture dest=12/0x55, then assert rst before the next edge -> qa(rs=12)=0, wb_pend=0; after release, array[12] remains 0.
